// File: rtl/grid_frame_scheduler.sv
// grid_frame_scheduler
// Paces the 16x32 falling-grid game and redraws it into the 160x120 VGA
// frame buffer. A step strobe is followed by a short settle window, a
// snapshot of the display vector and a cell-by-cell scan at one pixel per
// clock. Steps never overlap a redraw, so the drawn frame does not tear.
//
// Optional feature: define GRID_LINES_EN to paint the first pixel column
// and first pixel row of every cell blue (3'b001). The result is a visible
// cell grid, with the same pixel count and timing.
module grid_frame_scheduler #(
    parameter int unsigned CELL_W     = 8,
    parameter int unsigned CELL_H     = 3,
    parameter int unsigned X_OFF      = 16,
    parameter int unsigned Y_OFF      = 12,
    parameter int unsigned STEP_DELAY = 2500000,
    parameter logic [2:0]  FG_COLOUR  = 3'b111,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         run,
    input  logic         step,
    input  logic [511:0] display,
    output logic         game_enable,
    output logic [7:0]   x,
    output logic [6:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned DLY_W = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
    localparam int unsigned PX_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned PY_W  = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STEP_DELAY - 1);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL_W - 1);
    localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(CELL_H - 1);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_STEP   = 3'd1,
        S_SETTLE = 3'd2,
        S_LATCH  = 3'd3,
        S_DRAW   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Scaled cell offset: the product is kept at 9 bits and truncated by the caller.
    function automatic logic [8:0] scale9(input logic [8:0] idx, input logic [8:0] size);
        scale9 = idx * size;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [DLY_W-1:0]   dly_r;
    logic [DLY_W-1:0]   next_dly_s;
    logic               settle_r;
    logic [511:0]       shadow_r;
    logic [3:0]         col_r;
    logic [4:0]         row_r;
    logic [PX_W-1:0]    px_r;
    logic [PY_W-1:0]    py_r;
    logic               last_pixel_s;
    logic               cell_on_s;
    logic [7:0]         pix_x_s;
    logic [6:0]         pix_y_s;
    logic [2:0]         pix_colour_s;

    logic               game_enable_r;
    logic [7:0]         x_r;
    logic [6:0]         y_r;
    logic [2:0]         colour_r;
    logic               plot_r;
    logic               busy_r;
    logic               frame_done_r;

    assign game_enable = game_enable_r;
    assign x           = x_r;
    assign y           = y_r;
    assign colour      = colour_r;
    assign plot        = plot_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;

    assign last_pixel_s = (px_r == PX_LAST) && (py_r == PY_LAST) &&
                          (row_r == 5'd31) && (col_r == 4'd15);

    // Next-state and delay-counter logic; run/step are only looked at in S_WAIT.
    always_comb begin
        next_state_s = state_r;
        next_dly_s   = dly_r;
        case (state_r)
            S_WAIT: begin
                if (run) begin
                    if (dly_r == DLY_LAST) begin
                        next_dly_s   = {DLY_W{1'b0}};
                        next_state_s = S_STEP;
                    end else begin
                        next_dly_s   = dly_r + DLY_W'(1);
                    end
                end else if (step) begin
                    next_dly_s   = {DLY_W{1'b0}};
                    next_state_s = S_STEP;
                end else begin
                    next_dly_s   = dly_r;
                end
            end
            S_STEP: begin
                next_state_s = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_r) begin
                    next_state_s = S_LATCH;
                end else begin
                    next_state_s = S_SETTLE;
                end
            end
            S_LATCH: begin
                next_state_s = S_DRAW;
            end
            S_DRAW: begin
                if (last_pixel_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_DRAW;
                end
            end
            S_DONE: begin
                next_state_s = S_WAIT;
            end
            default: begin
                next_state_s = S_SETTLE;
            end
        endcase
    end

    // State, delay counter and two-cycle settle timer.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r  <= S_SETTLE;
            dly_r    <= {DLY_W{1'b0}};
            settle_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            dly_r    <= next_dly_s;
            settle_r <= (state_r == S_SETTLE) ? ~settle_r : 1'b0;
        end
    end

    // Snapshot of the game grid, taken once per redraw so mid-draw changes are ignored.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            shadow_r <= {512{1'b0}};
        end else if (state_r == S_LATCH) begin
            shadow_r <= display;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Scan counters: px innermost, then py, row and col.
    always_ff @(posedge clock) begin
        if (!resetn || state_r == S_LATCH) begin
            col_r <= 4'd0;
            row_r <= 5'd0;
            px_r  <= {PX_W{1'b0}};
            py_r  <= {PY_W{1'b0}};
        end else if (state_r == S_DRAW) begin
            if (px_r == PX_LAST) begin
                px_r <= {PX_W{1'b0}};
                if (py_r == PY_LAST) begin
                    py_r <= {PY_W{1'b0}};
                    if (row_r == 5'd31) begin
                        row_r <= 5'd0;
                        col_r <= col_r + 4'd1;
                    end else begin
                        row_r <= row_r + 5'd1;
                    end
                end else begin
                    py_r <= py_r + PY_W'(1);
                end
            end else begin
                px_r <= px_r + PX_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
            px_r  <= px_r;
            py_r  <= py_r;
        end
    end

    // Pixel address and colour for the cell and pixel the counters point at.
    always_comb begin
        cell_on_s = shadow_r[{col_r, row_r}];
        pix_x_s   = 8'(9'(X_OFF) + scale9({5'b00000, col_r}, 9'(CELL_W)) + 9'(px_r));
        pix_y_s   = 7'(9'(Y_OFF) + scale9({4'b0000, row_r}, 9'(CELL_H)) + 9'(py_r));
`ifdef GRID_LINES_EN
        if ((px_r == {PX_W{1'b0}}) || (py_r == {PY_W{1'b0}})) begin
            pix_colour_s = 3'b001;
        end else if (cell_on_s) begin
            pix_colour_s = FG_COLOUR;
        end else begin
            pix_colour_s = BG_COLOUR;
        end
`else
        if (cell_on_s) begin
            pix_colour_s = FG_COLOUR;
        end else begin
            pix_colour_s = BG_COLOUR;
        end
`endif
    end

    // Registered outputs; the pixel addressed in cycle n is presented in cycle n+1.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            game_enable_r <= 1'b0;
            x_r           <= 8'd0;
            y_r           <= 7'd0;
            colour_r      <= 3'b000;
            plot_r        <= 1'b0;
            busy_r        <= 1'b1;
            frame_done_r  <= 1'b0;
        end else begin
            game_enable_r <= (next_state_s == S_STEP);
            frame_done_r  <= (next_state_s == S_DONE);
            busy_r        <= (next_state_s != S_WAIT);
            plot_r        <= (state_r == S_DRAW);
            if (state_r == S_DRAW) begin
                x_r      <= pix_x_s;
                y_r      <= pix_y_s;
                colour_r <= pix_colour_s;
            end else begin
                x_r      <= x_r;
                y_r      <= y_r;
                colour_r <= colour_r;
            end
        end
    end

endmodule
